// File: rtl/dma_pkg.sv
// ---------------------------------------------------------------------------
// dma_pkg -- definitions shared by the DMA source and destination controllers.
//
// Contents:
//   BEAT_BYTES  : bytes moved per bus beat (beats are word aligned)
//   OFF_WD      : width of the byte offset inside a beat
//   dma_state_e : controller FSM encoding (IDLE is all-zero so a reset
//                 state reads as 0 on a debug port)
// ---------------------------------------------------------------------------
package dma_pkg;

    localparam int BEAT_BYTES = 4;
    localparam int OFF_WD     = 2;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        RSP  = 3'd2,
        PUSH = 3'd3,
        DONE = 3'd4
    } dma_state_e;

endpackage

// File: rtl/dma_be_gen.sv
// ---------------------------------------------------------------------------
// dma_be_gen -- combinational byte-enable generator for one bus beat.
//
// Ports:
//   offset    in  OFF_WD  byte offset of the transfer start inside its word
//   remaining in  LEN_WD  bytes still to move, including this beat
//   first     in  1       this is the first beat (offset applies)
//   be        out BE_WD   byte enables for this beat
//
// Byte m is enabled when lo <= m < lo + remaining, where lo is the offset on
// the first beat and 0 afterwards. This one rule covers the first, middle
// (remaining >= BE_WD gives all ones) and last beats.
// ---------------------------------------------------------------------------
module dma_be_gen
    import dma_pkg::*;
#(
    parameter int LEN_WD = 12,
    parameter int BE_WD  = 4
) (
    input  logic [OFF_WD-1:0] offset,
    input  logic [LEN_WD-1:0] remaining,
    input  logic              first,
    output logic [BE_WD-1:0]  be
);

    // One extra bit so lo + remaining cannot wrap for the largest length.
    localparam int EW = LEN_WD + 1;

    logic [EW-1:0] lo;
    logic [EW-1:0] hi;

    always_comb begin
        lo = first ? EW'(offset) : '0;
        hi = lo + {1'b0, remaining};
        be = '0;
        for (int m = 0; m < BE_WD; m++) begin
            be[m] = (EW'(m) >= lo) && (EW'(m) < hi);
        end
    end

endmodule

// File: rtl/dma_src_ctrl.sv
// ---------------------------------------------------------------------------
// dma_src_ctrl -- DMA channel source side: reads the source region through
// the core-bus load port one word at a time and pushes each word, with its
// byte enables, into the channel buffer.
//
// Ports:
//   clk_i, rstn_i            clock (rising edge) / async active-low reset
//   start_i                  one-cycle start pulse from the channel registers
//   src_addr_i               source byte address (latched at start)
//   data_length_i            transfer length in bytes (latched at start)
//   dst_idle_i               destination controller is idle
//   src_done_o               one-cycle pulse once every beat is in the buffer
//   src_idle_o               FSM is in IDLE
//   buf_w*                   write channel into the buffer
//   core_ld_*                core-bus load port (read only, we tied low)
//   dbg_state                current FSM state
//
// Handshakes: a transfer happens on a rising edge where valid (req) and
// ready (gnt) are both 1; valid never drops and its payload never changes
// until that edge. A same-cycle grant is accepted. Exactly one load is in
// flight, so rvalid is only looked at in RSP.
// ---------------------------------------------------------------------------
module dma_src_ctrl
    import dma_pkg::*;
#(
    parameter int DATA_WD = 32,
    parameter int ADDR_WD = 32,
    parameter int LEN_WD  = 12,
    parameter int BE_WD   = DATA_WD / 8
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               start_i,
    input  logic [ADDR_WD-1:0] src_addr_i,
    input  logic [LEN_WD-1:0]  data_length_i,
    input  logic               dst_idle_i,
    output logic               src_done_o,
    output logic               src_idle_o,
    output logic               buf_wvalid_o,
    input  logic               buf_wready_i,
    output logic [BE_WD-1:0]   buf_wbe_o,
    output logic [DATA_WD-1:0] buf_wdata_o,
    output logic               core_ld_req_o,
    input  logic               core_ld_gnt_i,
    output logic               core_ld_we_o,
    output logic [BE_WD-1:0]   core_ld_be_o,
    output logic [ADDR_WD-1:0] core_ld_addr_o,
    input  logic [DATA_WD-1:0] core_ld_rdata_i,
    input  logic               core_ld_rvalid_i,
    output dma_state_e         dbg_state
);

    dma_state_e        state;
    logic [LEN_WD-1:0] remaining;
    logic [LEN_WD-1:0] wbe_cnt;
    logic [LEN_WD-1:0] rem_next;
    logic [LEN_WD-1:0] gen_rem;
    logic              gen_first;
    logic [BE_WD-1:0]  gen_be;

    // Bytes carried by the beat currently offered to the buffer.
    always_comb begin
        wbe_cnt = '0;
        for (int m = 0; m < BE_WD; m++) begin
            wbe_cnt = wbe_cnt + LEN_WD'(buf_wbe_o[m]);
        end
    end

    assign rem_next = remaining - wbe_cnt;

    // The generator is shared by both points where a beat's enables are
    // loaded: at start (raw inputs, offset applies) and at the end of a push
    // (bytes left after this beat, no offset).
    assign gen_first = (state == IDLE);
    assign gen_rem   = gen_first ? data_length_i : rem_next;

    dma_be_gen #(
        .LEN_WD (LEN_WD),
        .BE_WD  (BE_WD)
    ) u_be_gen (
        .offset    (src_addr_i[OFF_WD-1:0]),
        .remaining (gen_rem),
        .first     (gen_first),
        .be        (gen_be)
    );

    assign core_ld_we_o = 1'b0;
    assign dbg_state    = state;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state          <= IDLE;
            remaining      <= '0;
            src_done_o     <= 1'b0;
            src_idle_o     <= 1'b1;
            buf_wvalid_o   <= 1'b0;
            buf_wbe_o      <= '0;
            buf_wdata_o    <= '0;
            core_ld_req_o  <= 1'b0;
            core_ld_be_o   <= '0;
            core_ld_addr_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i && dst_idle_i && (data_length_i != '0)) begin
                        state          <= REQ;
                        src_idle_o     <= 1'b0;
                        remaining      <= data_length_i;
                        core_ld_req_o  <= 1'b1;
                        core_ld_addr_o <= {src_addr_i[ADDR_WD-1:OFF_WD], {OFF_WD{1'b0}}};
                        core_ld_be_o   <= gen_be;
                    end
                end
                REQ: begin
                    if (core_ld_gnt_i) begin
                        core_ld_req_o <= 1'b0;
                        state         <= RSP;
                    end
                end
                RSP: begin
                    if (core_ld_rvalid_i) begin
                        buf_wdata_o  <= core_ld_rdata_i;
                        buf_wbe_o    <= core_ld_be_o;
                        buf_wvalid_o <= 1'b1;
                        state        <= PUSH;
                    end
                end
                PUSH: begin
                    if (buf_wready_i) begin
                        buf_wvalid_o <= 1'b0;
                        remaining    <= rem_next;
                        if (rem_next == '0) begin
                            state      <= DONE;
                            src_done_o <= 1'b1;
                        end else begin
                            state          <= REQ;
                            core_ld_req_o  <= 1'b1;
                            core_ld_addr_o <= core_ld_addr_o + ADDR_WD'(BEAT_BYTES);
                            core_ld_be_o   <= gen_be;
                        end
                    end
                end
                DONE: begin
                    src_done_o <= 1'b0;
                    src_idle_o <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    state      <= IDLE;
                    src_idle_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_src_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dma_src_ctrl -- directed bench for dma_src_ctrl. Tests push expected
// loads, buffer writes and done pulses into queues; a monitor pops and
// compares whenever the DUT presents one. A bus/buffer responder answers
// requests with programmable grant / ready delays and returns
// rdata = 0xD0000000 | address.
// ---------------------------------------------------------------------------
module tb_dma_src_ctrl;

    localparam int DATA_WD = 32;
    localparam int ADDR_WD = 32;
    localparam int LEN_WD  = 12;
    localparam int BE_WD   = 4;

    logic               clk_i = 1'b0;
    logic               rstn_i;
    logic               start_i;
    logic [ADDR_WD-1:0] src_addr_i;
    logic [LEN_WD-1:0]  data_length_i;
    logic               dst_idle_i;
    logic               src_done_o;
    logic               src_idle_o;
    logic               buf_wvalid_o;
    logic               buf_wready_i;
    logic [BE_WD-1:0]   buf_wbe_o;
    logic [DATA_WD-1:0] buf_wdata_o;
    logic               core_ld_req_o;
    logic               core_ld_gnt_i;
    logic               core_ld_we_o;
    logic [BE_WD-1:0]   core_ld_be_o;
    logic [ADDR_WD-1:0] core_ld_addr_o;
    logic [DATA_WD-1:0] core_ld_rdata_i;
    logic               core_ld_rvalid_i;
    logic [2:0]         dbg_state;

    dma_src_ctrl #(
        .DATA_WD (DATA_WD),
        .ADDR_WD (ADDR_WD),
        .LEN_WD  (LEN_WD),
        .BE_WD   (BE_WD)
    ) dut (
        .clk_i            (clk_i),
        .rstn_i           (rstn_i),
        .start_i          (start_i),
        .src_addr_i       (src_addr_i),
        .data_length_i    (data_length_i),
        .dst_idle_i       (dst_idle_i),
        .src_done_o       (src_done_o),
        .src_idle_o       (src_idle_o),
        .buf_wvalid_o     (buf_wvalid_o),
        .buf_wready_i     (buf_wready_i),
        .buf_wbe_o        (buf_wbe_o),
        .buf_wdata_o      (buf_wdata_o),
        .core_ld_req_o    (core_ld_req_o),
        .core_ld_gnt_i    (core_ld_gnt_i),
        .core_ld_we_o     (core_ld_we_o),
        .core_ld_be_o     (core_ld_be_o),
        .core_ld_addr_o   (core_ld_addr_o),
        .core_ld_rdata_i  (core_ld_rdata_i),
        .core_ld_rvalid_i (core_ld_rvalid_i),
        .dbg_state        (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk_i = ~clk_i;

    // ---------------- scoreboard state ----------------
    logic [ADDR_WD+BE_WD-1:0] exp_ld_q[$];
    logic [BE_WD+DATA_WD-1:0] exp_wr_q[$];
    logic                     exp_done_q[$];

    int errors = 0;
    int checks = 0;

    // responder controls (written only by the main process)
    int gnt_delay    = 0;
    int wready_delay = 0;
    int spur_req     = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_evt(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got 1 expected 0 (no entry expected)", name);
    endtask

    task automatic push_ld(input logic [ADDR_WD-1:0] a, input logic [BE_WD-1:0] be);
        exp_ld_q.push_back({a, be});
    endtask

    task automatic push_wr(input logic [BE_WD-1:0] be, input logic [DATA_WD-1:0] d);
        exp_wr_q.push_back({be, d});
    endtask

    // ---------------- bus / buffer responder ----------------
    initial begin : responder
        logic               rsp_pending;
        logic [ADDR_WD-1:0] pend_addr;
        int                 ld_wait;
        int                 wr_wait;
        int                 spur_done;
        core_ld_gnt_i    = 1'b0;
        core_ld_rvalid_i = 1'b0;
        core_ld_rdata_i  = '0;
        buf_wready_i     = 1'b0;
        rsp_pending      = 1'b0;
        pend_addr        = '0;
        ld_wait          = 0;
        wr_wait          = 0;
        spur_done        = 0;
        forever begin
            @(posedge clk_i);
            #1;
            core_ld_gnt_i    = 1'b0;
            core_ld_rvalid_i = 1'b0;
            buf_wready_i     = 1'b0;
            if (rsp_pending) begin
                core_ld_rvalid_i = 1'b1;
                core_ld_rdata_i  = 32'hD000_0000 | pend_addr;
                rsp_pending      = 1'b0;
            end else if (spur_req != spur_done) begin
                core_ld_rvalid_i = 1'b1;
                core_ld_rdata_i  = 32'hBAD0_BAD0;
                spur_done++;
            end
            if (core_ld_req_o) begin
                if (ld_wait >= gnt_delay) begin
                    core_ld_gnt_i = 1'b1;
                    pend_addr     = core_ld_addr_o;
                    rsp_pending   = 1'b1;
                    ld_wait       = 0;
                end else begin
                    ld_wait++;
                end
            end
            if (buf_wvalid_o) begin
                if (wr_wait >= wready_delay) begin
                    buf_wready_i = 1'b1;
                    wr_wait      = 0;
                end else begin
                    wr_wait++;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    // Every cycle a valid is up its payload is compared with the head entry,
    // which also checks it stays stable; the entry is popped on handshake.
    initial begin : monitor
        forever begin
            @(negedge clk_i);
            if (rstn_i) begin
                if (core_ld_req_o) begin
                    check("ld_we", {63'd0, core_ld_we_o}, 64'd0);
                    if (exp_ld_q.size() == 0) begin
                        fail_evt("unexpected_load_req");
                    end else begin
                        check("ld_addr_be", {28'd0, core_ld_addr_o, core_ld_be_o}, {28'd0, exp_ld_q[0]});
                        if (core_ld_gnt_i) void'(exp_ld_q.pop_front());
                    end
                end
                if (buf_wvalid_o) begin
                    if (exp_wr_q.size() == 0) begin
                        fail_evt("unexpected_buf_write");
                    end else begin
                        check("wr_be_data", {28'd0, buf_wbe_o, buf_wdata_o}, {28'd0, exp_wr_q[0]});
                        if (buf_wready_i) void'(exp_wr_q.pop_front());
                    end
                end
                if (src_done_o) begin
                    if (exp_done_q.size() == 0) fail_evt("unexpected_src_done");
                    else void'(exp_done_q.pop_front());
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic start_xfer(input logic [ADDR_WD-1:0] a, input logic [LEN_WD-1:0] len,
                              input logic dsti);
        @(posedge clk_i);
        #1;
        src_addr_i    = a;
        data_length_i = len;
        dst_idle_i    = dsti;
        start_i       = 1'b1;
        @(posedge clk_i);
        #1;
        start_i       = 1'b0;
        dst_idle_i    = 1'b1;
        // scramble the inputs: the transfer must run on the latched copies
        src_addr_i    = $urandom;
        data_length_i = LEN_WD'($urandom_range(1, 4095));
    endtask

    task automatic wait_drain(input string name, input int bound);
        int n;
        n = 0;
        while (!(exp_ld_q.size() == 0 && exp_wr_q.size() == 0 && exp_done_q.size() == 0
                 && src_idle_o) && n < bound) begin
            @(negedge clk_i);
            n++;
        end
        check({name, "_drained"}, {63'd0, n < bound}, 64'd1);
        // trailing cycles let the monitor catch duplicate beats or pulses
        repeat (6) @(negedge clk_i);
        check({name, "_idle_after"}, {63'd0, src_idle_o}, 64'd1);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_req"},   {63'd0, core_ld_req_o}, 64'd0);
        check({name, "_addr"},  {32'd0, core_ld_addr_o}, 64'd0);
        check({name, "_be"},    {60'd0, core_ld_be_o}, 64'd0);
        check({name, "_we"},    {63'd0, core_ld_we_o}, 64'd0);
        check({name, "_wvalid"},{63'd0, buf_wvalid_o}, 64'd0);
        check({name, "_wbe"},   {60'd0, buf_wbe_o}, 64'd0);
        check({name, "_wdata"}, {32'd0, buf_wdata_o}, 64'd0);
        check({name, "_done"},  {63'd0, src_done_o}, 64'd0);
        check({name, "_idle"},  {63'd0, src_idle_o}, 64'd1);
        check({name, "_state"}, {61'd0, dbg_state}, 64'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin : watchdog
        #2_000_000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

    // ---------------- tests ----------------
    initial begin : main
        int gnts;
        int n;
        rstn_i        = 1'b0;
        start_i       = 1'b0;
        src_addr_i    = '0;
        data_length_i = '0;
        dst_idle_i    = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        check_reset_outputs("por");
        rstn_i = 1'b1;
        repeat (3) @(negedge clk_i);
        check("por_no_req", {63'd0, core_ld_req_o}, 64'd0);

        // aligned two-beat transfer, no back-pressure
        push_ld(32'h100, 4'b1111); push_ld(32'h104, 4'b1111);
        push_wr(4'b1111, 32'hD000_0100); push_wr(4'b1111, 32'hD000_0104);
        exp_done_q.push_back(1'b1);
        start_xfer(32'h100, 12'd8, 1'b1);
        check("t_aligned_busy", {63'd0, src_idle_o}, 64'd0);
        wait_drain("t_aligned", 100);

        // unaligned start and end: three beats, 1+4+1 bytes
        push_ld(32'h100, 4'b1000); push_ld(32'h104, 4'b1111); push_ld(32'h108, 4'b0001);
        push_wr(4'b1000, 32'hD000_0100); push_wr(4'b1111, 32'hD000_0104);
        push_wr(4'b0001, 32'hD000_0108);
        exp_done_q.push_back(1'b1);
        start_xfer(32'h103, 12'd6, 1'b1);
        wait_drain("t_unaligned", 100);

        // short transfer inside one word
        push_ld(32'h100, 4'b0110);
        push_wr(4'b0110, 32'hD000_0100);
        exp_done_q.push_back(1'b1);
        start_xfer(32'h101, 12'd2, 1'b1);
        wait_drain("t_inword", 100);

        // slow grant and slow buffer
        gnt_delay = 5; wready_delay = 3;
        push_ld(32'h200, 4'b1111); push_ld(32'h204, 4'b1111); push_ld(32'h208, 4'b1111);
        push_wr(4'b1111, 32'hD000_0200); push_wr(4'b1111, 32'hD000_0204);
        push_wr(4'b1111, 32'hD000_0208);
        exp_done_q.push_back(1'b1);
        start_xfer(32'h200, 12'd12, 1'b1);
        wait_drain("t_backpressure", 300);
        gnt_delay = 0; wready_delay = 0;

        // starts that must be ignored, plus a stray rvalid while idle
        start_xfer(32'h700, 12'd8, 1'b0);
        start_xfer(32'h700, 12'd0, 1'b1);
        spur_req++;
        repeat (20) @(negedge clk_i);
        check("t_ignored_req", {63'd0, core_ld_req_o}, 64'd0);
        check("t_ignored_idle", {63'd0, src_idle_o}, 64'd1);
        check("t_ignored_wvalid", {63'd0, buf_wvalid_o}, 64'd0);

        // start while busy is ignored
        push_ld(32'h300, 4'b1111); push_ld(32'h304, 4'b1111);
        push_wr(4'b1111, 32'hD000_0300); push_wr(4'b1111, 32'hD000_0304);
        exp_done_q.push_back(1'b1);
        start_xfer(32'h300, 12'd8, 1'b1);
        start_xfer(32'h400, 12'd4, 1'b1);
        wait_drain("t_busy_start", 100);

        // reset while beat 2 is waiting for its response
        push_ld(32'h500, 4'b1111); push_ld(32'h504, 4'b1111);
        push_wr(4'b1111, 32'hD000_0500);
        start_xfer(32'h500, 12'd12, 1'b1);
        gnts = 0; n = 0;
        while (gnts < 2 && n < 100) begin
            @(negedge clk_i);
            if (core_ld_req_o && core_ld_gnt_i) gnts++;
            n++;
        end
        check("t_rst_reach_beat2", 64'(gnts), 64'd2);
        @(posedge clk_i);
        #2;
        rstn_i = 1'b0;
        #1;
        check_reset_outputs("t_rst_mid");
        check("t_rst_queues", 64'(exp_ld_q.size() + exp_wr_q.size() + exp_done_q.size()), 64'd0);
        repeat (3) @(posedge clk_i);
        #1;
        rstn_i = 1'b1;
        repeat (20) @(negedge clk_i);
        check("t_rst_no_req", {63'd0, core_ld_req_o}, 64'd0);
        push_ld(32'h600, 4'b1111);
        push_wr(4'b1111, 32'hD000_0600);
        exp_done_q.push_back(1'b1);
        start_xfer(32'h600, 12'd4, 1'b1);
        wait_drain("t_rst_restart", 100);

        // maximum length from offset 3: 1 + 1023 + 1 beats
        for (int i = 0; i < 1025; i++) begin
            logic [ADDR_WD-1:0] a;
            logic [BE_WD-1:0]   be;
            a  = 32'h1000 + 32'(4 * i);
            be = (i == 0) ? 4'b1000 : ((i == 1024) ? 4'b0011 : 4'b1111);
            push_ld(a, be);
            push_wr(be, 32'hD000_0000 | a);
        end
        exp_done_q.push_back(1'b1);
        start_xfer(32'h1003, 12'd4095, 1'b1);
        wait_drain("t_maxlen", 6000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
